// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: op and width codes, FSM states
// and the byte-count helper used by the transfer sequencer.
package mem_stage_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;
    localparam logic [1:0] MEM_RSVD  = 2'b11;

    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Index of the final byte beat; the reserved width code behaves as a word.
    function automatic logic [1:0] last_beat(input logic [1:0] width);
        case (width)
            WIDTH_B: return 2'd0;
            WIDTH_H: return 2'd1;
            WIDTH_W: return 2'd3;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [1:0] op);
        return !(op == MEM_NONE || op == MEM_RSVD);
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Turns the little-endian load assembly register into the 32-bit writeback
// value, sign- or zero-extending byte and half loads.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] asm_in,
    input  logic [1:0]  width_in,
    input  logic        signed_in,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = asm_in;
        case (width_in)
            WIDTH_B: data_out = {{24{signed_in & asm_in[7]}}, asm_in[7:0]};
            WIDTH_H: data_out = {{16{signed_in & asm_in[15]}}, asm_in[15:0]};
            default: data_out = asm_in;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through in one cycle and
// runs loads/stores as byte-serial req/ack transfers, stalling upstream meanwhile.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic        rdE_in,
    input  logic [4:0]  rdIdx_in,
    input  logic [31:0] rdData_in,
    input  logic [1:0]  memOp_in,
    input  logic [1:0]  memWidth_in,
    input  logic        loadSigned_in,
    input  logic [31:0] storeData_in,
    output logic        stall_out,
    output logic        memReq_out,
    output logic        memWr_out,
    output logic [31:0] memAddr_out,
    output logic [7:0]  memWData_out,
    input  logic [7:0]  memRData_in,
    input  logic        memAck_in,
    output logic        valid_out,
    output logic        rdE_out,
    output logic [4:0]  rdIdx_out,
    output logic [31:0] rdData_out
);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  width_q, width_d;
    logic        sgn_q, sgn_d;
    logic        store_q, store_d;
    logic [31:0] sdata_q, sdata_d;
    logic        rde_q, rde_d;
    logic [4:0]  rdidx_q, rdidx_d;
    logic [31:0] asm_q, asm_d;
    logic        valid_out_q, valid_out_d;
    logic        rde_out_q, rde_out_d;
    logic [4:0]  rdidx_out_q, rdidx_out_d;
    logic [31:0] rddata_out_q, rddata_out_d;

    logic        busy;
    logic [31:0] asm_merged;
    logic [31:0] load_data;

    assign busy = (state_q == ST_BUSY);

    // Assembly with the acknowledged read byte already placed in its lane, so
    // the final beat's result can be extended and registered on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit = busy & memAck_in & ~store_q & (cnt_q == 2'(gi));
            assign asm_merged[gi*8 +: 8] = lane_hit ? memRData_in : asm_q[gi*8 +: 8];
        end
    endgenerate

    load_extend u_load_extend (
        .asm_in    (asm_merged),
        .width_in  (width_q),
        .signed_in (sgn_q),
        .data_out  (load_data)
    );

    assign stall_out    = busy | (valid_in & is_mem_op(memOp_in));
    assign memReq_out   = busy;
    assign memWr_out    = busy & store_q;
    assign memAddr_out  = busy ? (addr_q + {30'd0, cnt_q}) : 32'd0;
    assign memWData_out = (busy & store_q) ? 8'(sdata_q >> {cnt_q, 3'b000}) : 8'd0;

    assign valid_out  = valid_out_q;
    assign rdE_out    = rde_out_q;
    assign rdIdx_out  = rdidx_out_q;
    assign rdData_out = rddata_out_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        width_d      = width_q;
        sgn_d        = sgn_q;
        store_d      = store_q;
        sdata_d      = sdata_q;
        rde_d        = rde_q;
        rdidx_d      = rdidx_q;
        asm_d        = asm_q;
        valid_out_d  = 1'b0;
        rde_out_d    = rde_out_q;
        rdidx_out_d  = rdidx_out_q;
        rddata_out_d = rddata_out_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    if (is_mem_op(memOp_in)) begin
                        state_d = ST_BUSY;
                        cnt_d   = 2'd0;
                        addr_d  = rdData_in;
                        width_d = memWidth_in;
                        sgn_d   = loadSigned_in;
                        store_d = (memOp_in == MEM_STORE);
                        sdata_d = storeData_in;
                        rde_d   = rdE_in;
                        rdidx_d = rdIdx_in;
                        asm_d   = 32'd0;
                    end else begin
                        valid_out_d  = 1'b1;
                        rde_out_d    = rdE_in;
                        rdidx_out_d  = rdIdx_in;
                        rddata_out_d = rdData_in;
                    end
                end
            end
            ST_BUSY: begin
                if (memAck_in) begin
                    asm_d = asm_merged;
                    if (cnt_q == last_beat(width_q)) begin
                        state_d      = ST_IDLE;
                        valid_out_d  = 1'b1;
                        rde_out_d    = rde_q & ~store_q;
                        rdidx_out_d  = rdidx_q;
                        rddata_out_d = store_q ? 32'd0 : load_data;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            addr_q       <= 32'd0;
            width_q      <= 2'd0;
            sgn_q        <= 1'b0;
            store_q      <= 1'b0;
            sdata_q      <= 32'd0;
            rde_q        <= 1'b0;
            rdidx_q      <= 5'd0;
            asm_q        <= 32'd0;
            valid_out_q  <= 1'b0;
            rde_out_q    <= 1'b0;
            rdidx_out_q  <= 5'd0;
            rddata_out_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            width_q      <= width_d;
            sgn_q        <= sgn_d;
            store_q      <= store_d;
            sdata_q      <= sdata_d;
            rde_q        <= rde_d;
            rdidx_q      <= rdidx_d;
            asm_q        <= asm_d;
            valid_out_q  <= valid_out_d;
            rde_out_q    <= rde_out_d;
            rdidx_out_q  <= rdidx_out_d;
            rddata_out_q <= rddata_out_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a byte-addressed memory model serves the
// req/ack port and predicts every load/store result from arithmetic on bytes.
module tb_mem_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic        rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rdData_in;
    logic [1:0]  memOp_in;
    logic [1:0]  memWidth_in;
    logic        loadSigned_in;
    logic [31:0] storeData_in;
    logic        stall_out;
    logic        memReq_out;
    logic        memWr_out;
    logic [31:0] memAddr_out;
    logic [7:0]  memWData_out;
    logic [7:0]  memRData_in;
    logic        memAck_in;
    logic        valid_out;
    logic        rdE_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] mem_model [logic [31:0]];

    always #5 clk_in = ~clk_in;

    mem_stage dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .valid_in      (valid_in),
        .rdE_in        (rdE_in),
        .rdIdx_in      (rdIdx_in),
        .rdData_in     (rdData_in),
        .memOp_in      (memOp_in),
        .memWidth_in   (memWidth_in),
        .loadSigned_in (loadSigned_in),
        .storeData_in  (storeData_in),
        .stall_out     (stall_out),
        .memReq_out    (memReq_out),
        .memWr_out     (memWr_out),
        .memAddr_out   (memAddr_out),
        .memWData_out  (memWData_out),
        .memRData_in   (memRData_in),
        .memAck_in     (memAck_in),
        .valid_out     (valid_out),
        .rdE_out       (rdE_out),
        .rdIdx_out     (rdIdx_out),
        .rdData_out    (rdData_out)
    );

    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : 8'h00;
    endfunction

    // One ALU (non-memory) instruction; op is 00 or the reserved 11.
    task automatic do_alu_op(input logic [1:0] op, input logic rde, input logic [4:0] idx,
                             input logic [31:0] data, input string name);
        valid_in = 1'b1; memOp_in = op; rdE_in = rde; rdIdx_in = idx; rdData_in = data;
        memWidth_in = 2'($urandom); loadSigned_in = 1'($urandom); storeData_in = $urandom;
        #1;
        total_cnt++;
        if (stall_out !== 1'b0 || memReq_out !== 1'b0)
            $display("FAIL %s stall/req: got %b/%b expected 0/0", name, stall_out, memReq_out);
        else pass_cnt++;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        total_cnt++;
        if (valid_out !== 1'b1 || rdE_out !== rde || rdIdx_out !== idx || rdData_out !== data)
            $display("FAIL %s result: got v=%b e=%b i=%0d d=%h expected v=1 e=%b i=%0d d=%h",
                     name, valid_out, rdE_out, rdIdx_out, rdData_out, rde, idx, data);
        else pass_cnt++;
        $display("alu  %s op=%b idx=%0d data=%h", name, op, idx, data);
    endtask

    // One load or store with wait_cyc idle cycles before every ack.
    task automatic do_mem_op(input logic [1:0] op, input logic [1:0] width, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic rde, input logic [4:0] idx, input int wait_cyc,
                             input string name, output logic [31:0] got);
        int n;
        longint v;
        logic [31:0] exp_data;
        logic [7:0] exp_wb;
        logic is_st;
        is_st = (op == 2'b10);
        n = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(rd_mem(addr + 32'(i))) << (8 * i);
        if (sgn && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        exp_data = is_st ? 32'd0 : v[31:0];

        valid_in = 1'b1; memOp_in = op; memWidth_in = width; loadSigned_in = sgn;
        rdE_in = rde; rdIdx_in = idx; rdData_in = addr; storeData_in = sdata; memAck_in = 1'b0;
        #1;
        total_cnt++;
        if (stall_out !== 1'b1) $display("FAIL %s accept stall: got %b expected 1", name, stall_out);
        else pass_cnt++;
        @(posedge clk_in); #1;
        // Scramble the inputs so the stage must rely on its latched copies.
        valid_in = 1'b0; rdData_in = $urandom; storeData_in = $urandom;
        memWidth_in = ~width; loadSigned_in = ~sgn; rdE_in = ~rde; rdIdx_in = ~idx;
        total_cnt++;
        if (valid_out !== 1'b0) $display("FAIL %s early valid: got %b expected 0", name, valid_out);
        else pass_cnt++;
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w <= wait_cyc; w++) begin
                memAck_in = (w == wait_cyc);
                memRData_in = (memAck_in && !is_st) ? rd_mem(addr + 32'(i)) : 8'($urandom);
                #1;
                exp_wb = is_st ? 8'(sdata >> (8 * i)) : 8'd0;
                total_cnt++;
                if (memReq_out !== 1'b1 || memWr_out !== is_st || memAddr_out !== addr + 32'(i) ||
                    stall_out !== 1'b1 || memWData_out !== exp_wb)
                    $display("FAIL %s beat%0d: got req=%b wr=%b a=%h st=%b wd=%h expected req=1 wr=%b a=%h st=1 wd=%h",
                             name, i, memReq_out, memWr_out, memAddr_out, stall_out, memWData_out,
                             is_st, addr + 32'(i), exp_wb);
                else pass_cnt++;
                if (memAck_in && is_st) mem_model[addr + 32'(i)] = exp_wb;
                @(posedge clk_in); #1;
                memAck_in = 1'b0;
            end
        end
        total_cnt++;
        if (valid_out !== 1'b1 || rdE_out !== (rde & ~is_st) || rdData_out !== exp_data ||
            (!is_st && rdIdx_out !== idx) || stall_out !== 1'b0 || memReq_out !== 1'b0)
            $display("FAIL %s result: got v=%b e=%b i=%0d d=%h st=%b req=%b expected v=1 e=%b i=%0d d=%h st=0 req=0",
                     name, valid_out, rdE_out, rdIdx_out, rdData_out, stall_out, memReq_out,
                     rde & ~is_st, idx, exp_data);
        else pass_cnt++;
        got = rdData_out;
        $display("mem  %s op=%b w=%b s=%b addr=%h wait=%0d data=%h", name, op, width, sgn, addr, wait_cyc, got);
    endtask

    task automatic test_reset();
        rst_in = 1'b1; valid_in = 1'b0; rdE_in = 1'b0; rdIdx_in = 5'd0; rdData_in = 32'd0;
        memOp_in = 2'b00; memWidth_in = 2'b00; loadSigned_in = 1'b0; storeData_in = 32'd0;
        memRData_in = 8'd0; memAck_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        total_cnt++;
        if ({stall_out, memReq_out, memWr_out, memAddr_out, memWData_out,
             valid_out, rdE_out, rdIdx_out, rdData_out} !== '0)
            $display("FAIL reset outputs: got st=%b req=%b wr=%b a=%h wd=%h v=%b e=%b i=%0d d=%h expected all 0",
                     stall_out, memReq_out, memWr_out, memAddr_out, memWData_out,
                     valid_out, rdE_out, rdIdx_out, rdData_out);
        else pass_cnt++;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        total_cnt++;
        if (valid_out !== 1'b0 || stall_out !== 1'b0)
            $display("FAIL idle no-valid: got v=%b st=%b expected 0/0", valid_out, stall_out);
        else pass_cnt++;
        $display("rst  reset released");
    endtask

    task automatic test_alu();
        do_alu_op(2'b00, 1'b1, 5'd5, 32'h1234_5678, "alu");
        total_cnt++;
        if (valid_out !== 1'b1) $display("FAIL alu pulse: got %b expected 1", valid_out);
        else pass_cnt++;
        @(posedge clk_in); #1;
        total_cnt++;
        if (valid_out !== 1'b0) $display("FAIL alu pulse end: got %b expected 0", valid_out);
        else pass_cnt++;
        do_alu_op(2'b11, 1'b0, 5'd31, 32'hCAFE_0001, "alu_rsvd");
    endtask

    task automatic test_word_load();
        logic [31:0] got;
        mem_model[32'h100] = 8'h78; mem_model[32'h101] = 8'h56;
        mem_model[32'h102] = 8'h34; mem_model[32'h103] = 8'h12;
        do_mem_op(2'b01, 2'b10, 1'b0, 32'h100, 32'd0, 1'b1, 5'd7, 0, "word_load", got);
        total_cnt++;
        if (got !== 32'h1234_5678) $display("FAIL word_load const: got %h expected 12345678", got);
        else pass_cnt++;
    endtask

    task automatic test_extend();
        logic [31:0] got;
        mem_model[32'h200] = 8'h80;
        do_mem_op(2'b01, 2'b00, 1'b1, 32'h200, 32'd0, 1'b1, 5'd3, 0, "byte_signed", got);
        total_cnt++;
        if (got !== 32'hFFFF_FF80) $display("FAIL byte_signed const: got %h expected ffffff80", got);
        else pass_cnt++;
        mem_model[32'h300] = 8'h01; mem_model[32'h301] = 8'h80;
        do_mem_op(2'b01, 2'b01, 1'b0, 32'h300, 32'd0, 1'b1, 5'd4, 0, "half_unsigned", got);
        total_cnt++;
        if (got !== 32'h0000_8001) $display("FAIL half_unsigned const: got %h expected 00008001", got);
        else pass_cnt++;
    endtask

    task automatic test_store_wrap();
        logic [31:0] got;
        do_mem_op(2'b10, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 5'd9, 0, "store_wrap", got);
        total_cnt++;
        if (rd_mem(32'hFFFF_FFFF) !== 8'hEF || rd_mem(32'h0) !== 8'hBE)
            $display("FAIL store_wrap bytes: got %h %h expected ef be", rd_mem(32'hFFFF_FFFF), rd_mem(32'h0));
        else pass_cnt++;
    endtask

    task automatic test_wait();
        logic [31:0] got;
        for (int i = 0; i < 4; i++) mem_model[32'h500 + 32'(i)] = 8'($urandom);
        do_mem_op(2'b01, 2'b10, 1'b1, 32'h500, 32'd0, 1'b1, 5'd12, 3, "word_wait3", got);
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        logic [1:0] op;
        logic [31:0] addr;
        for (int t = 0; t < 30; t++) begin
            op = 2'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                               : 32'h1000 + 32'($urandom_range(0, 31));
            if (op == 2'b00 || op == 2'b11)
                do_alu_op(op, 1'($urandom), 5'($urandom), $urandom, "rand_alu");
            else
                do_mem_op(op, 2'($urandom), 1'($urandom), addr, $urandom, 1'($urandom),
                          5'($urandom), $urandom_range(0, 2), "rand_mem", got);
        end
    endtask

    task automatic test_reset_mid();
        valid_in = 1'b1; memOp_in = 2'b01; memWidth_in = 2'b10; loadSigned_in = 1'b0;
        rdE_in = 1'b1; rdIdx_in = 5'd6; rdData_in = 32'h400;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            memAck_in = 1'b1; memRData_in = 8'($urandom);
            @(posedge clk_in); #1;
        end
        memAck_in = 1'b0; rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        total_cnt++;
        if (memReq_out !== 1'b0 || valid_out !== 1'b0 || stall_out !== 1'b0)
            $display("FAIL reset_mid: got req=%b v=%b st=%b expected 0/0/0", memReq_out, valid_out, stall_out);
        else pass_cnt++;
        memAck_in = 1'b1; memRData_in = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            total_cnt++;
            if (valid_out !== 1'b0 || memReq_out !== 1'b0)
                $display("FAIL stray_ack%0d: got v=%b req=%b expected 0/0", i, valid_out, memReq_out);
            else pass_cnt++;
        end
        memAck_in = 1'b0;
        $display("rst  reset during word load, stray acks ignored");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_word_load();
        test_extend();
        test_store_wrap();
        test_wait();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
